// File: rtl/spi_xfer_engine_if.sv
// FIFO-side handshake and SPI serial lines of the transfer engine.
interface spi_xfer_engine_if #(
   parameter int DW = 8
);
   logic [DW-1:0] tx_dout;
   logic          tx_empty;
   logic          tx_re;
   logic [DW-1:0] rx_din;
   logic          rx_we;
   logic          rx_full;
   logic          sck;
   logic          mosi;
   logic          miso;

   // Engine side: pops the TX FIFO, pushes the RX FIFO, drives the SPI master lines.
   modport master (
      input  tx_dout, tx_empty, rx_full, miso,
      output tx_re, rx_din, rx_we, sck, mosi
   );

   // FIFO / slave side.
   modport slave (
      output tx_dout, tx_empty, rx_full, miso,
      input  tx_re, rx_din, rx_we, sck, mosi
   );
endinterface

// File: rtl/spi_xfer_engine.sv
// SPI master word engine: pops a word from the TX FIFO, shifts it out MSB-first
// while shifting MISO in, then pushes the received word into the RX FIFO.
module spi_xfer_engine #(
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [3:0]        div,
   spi_xfer_engine_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              rx_ovf
);

   localparam int             ECW        = $clog2(2 * DW + 1);
   localparam logic [ECW-1:0] FIRST_EDGE = ECW'(1);
   localparam logic [ECW-1:0] LAST_EDGE  = ECW'(2 * DW);

   typedef enum logic [1:0] {IDLE, XFER, STORE} state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  sreg_q, sreg_d;
   logic           rbit_q, rbit_d;
   logic           sck_q, sck_d;
   logic           cpha_q, cpha_d;
   logic [3:0]     div_lat_q, div_lat_d;
   logic [3:0]     div_cnt_q, div_cnt_d;
   logic [ECW-1:0] edge_cnt_q, edge_cnt_d;

   logic           start;
   logic           edge_evt;
   logic [ECW-1:0] edge_num;
   logic           do_sample;
   logic           do_shift;

   // NOTE: the pop strobe is combinational from IDLE, so it is qualified with the
   // async reset as well; otherwise a non-empty FIFO would be popped during reset.
   assign start    = rst && !clr && en && !bus.tx_empty && (state_q == IDLE);
   assign edge_evt = (state_q == XFER) && (div_cnt_q == div_lat_q);
   assign edge_num = edge_cnt_q + FIRST_EDGE;

   // cpha=0 samples on odd edges, cpha=1 on even ones; shifting uses the other
   // parity, minus the very first edge (cpha=1) and the very last edge (cpha=0).
   assign do_sample = edge_evt && (edge_num[0] ^ cpha_q);
   assign do_shift  = edge_evt && !(edge_num[0] ^ cpha_q)
                      && (edge_num != FIRST_EDGE) && (edge_num != LAST_EDGE);

   // Next-state and datapath update for the IDLE -> XFER -> STORE sequence.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d    = state_q;
      sreg_d     = sreg_q;
      rbit_d     = rbit_q;
      sck_d      = sck_q;
      cpha_d     = cpha_q;
      div_lat_d  = div_lat_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;

      unique case (state_q)
         IDLE: begin
            sck_d = cpol;
            if (start) begin
               // sck_q starting at cpol is the latched polarity for this word.
               state_d    = XFER;
               sreg_d     = bus.tx_dout;
               cpha_d     = cpha;
               div_lat_d  = div;
               div_cnt_d  = '0;
               edge_cnt_d = '0;
            end
         end
         XFER: begin
            if (edge_evt) begin
               div_cnt_d  = '0;
               edge_cnt_d = edge_num;
               sck_d      = ~sck_q;
               if (edge_num == LAST_EDGE) begin
                  state_d = STORE;
               end
            end else begin
               div_cnt_d = div_cnt_q + 4'd1;
            end
            if (do_sample) begin
               rbit_d = bus.miso;
            end
            if (do_shift) begin
               sreg_d = {sreg_q[DW-2:0], rbit_q};
            end
         end
         STORE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything, including a start in IDLE.
      if (clr) begin
         state_d    = IDLE;
         sck_d      = cpol;
         div_cnt_d  = '0;
         edge_cnt_d = '0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         rbit_q     <= 1'b0;
         sck_q      <= 1'b0;
         cpha_q     <= 1'b0;
         div_lat_q  <= '0;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values together.
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         rbit_q     <= rbit_d;
         sck_q      <= sck_d;
         cpha_q     <= cpha_d;
         div_lat_q  <= div_lat_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign bus.tx_re  = start;
   assign bus.sck    = sck_q;
   assign bus.mosi   = sreg_q[DW-1];
   assign bus.rx_din = {sreg_q[DW-2:0], rbit_q};
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == STORE) && !clr;
   assign bus.rx_we  = done && !bus.rx_full;
   assign rx_ovf     = done && bus.rx_full;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Bench for spi_xfer_engine: a transfer-level model predicts every output each
// cycle; directed scenarios add literal expectations for latency and data.
module tb_spi_xfer_engine;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, clr, en, cpol, cpha;
   logic [3:0]    div;
   logic          rx_full, loopback, slave_bit;
   logic [DW-1:0] pat;
   logic          busy, done, rx_ovf;

   logic [DW-1:0] tx_mem [16];
   logic [4:0]    wr_ptr = '0;
   logic [4:0]    rd_ptr = '0;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int sck_rises = 0;
   int tre_cyc[$];
   int we_cyc[$];
   int done_cyc[$];
   int ovf_cyc[$];
   logic [DW-1:0] we_data[$];

   spi_xfer_engine_if #(.DW(DW)) bus ();

   spi_xfer_engine #(.DW(DW)) dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en),
      .cpol   (cpol),
      .cpha   (cpha),
      .div    (div),
      .bus    (bus),
      .busy   (busy),
      .done   (done),
      .rx_ovf (rx_ovf)
   );

   always #5 clk = ~clk;

   // Transmit FIFO: array written by the stimulus, read pointer advanced by pops.
   assign bus.tx_empty = (rd_ptr == wr_ptr);
   assign bus.tx_dout  = tx_mem[rd_ptr[3:0]];
   assign bus.rx_full  = rx_full;
   assign bus.miso     = loopback ? bus.mosi : slave_bit;

   always @(posedge clk) if (bus.tx_re) rd_ptr <= rd_ptr + 5'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // SPI slave: presents pat MSB-first, changing data on its launch edges.
   initial begin : slave
      int e, j;
      logic sck_prev;
      e = 0;
      sck_prev = 1'b0;
      slave_bit = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!busy) e = 0;
         else if (bus.sck !== sck_prev) e++;
         sck_prev = bus.sck;
         if (cpha) j = (e <= 1) ? 0 : (e - 1) / 2;
         else j = e / 2;
         if (j > DW - 1) j = DW - 1;
         slave_bit = pat[DW-1-j];
      end
   end

   // Transfer-level model and per-cycle comparison, sampled mid-cycle.
   initial begin : compare
      bit            m_active;
      int            m_start, m_d, k, len, edges, j;
      logic          m_cpol, m_cpha, last_cpol, sck_prev;
      logic [DW-1:0] m_tx, m_rx;
      logic          exp_tre, exp_busy, exp_done, exp_we, exp_ovf, exp_sck, exp_mosi;
      m_active = 0; m_start = 0; m_d = 0; k = 0; len = 0;
      m_cpol = 0; m_cpha = 0; last_cpol = 0; sck_prev = 0; m_tx = '0; m_rx = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.sck === 1'b1 && sck_prev === 1'b0) sck_rises++;
         sck_prev = bus.sck;
         if (!rst) begin
            check("rst_tx_re", bus.tx_re, 0);
            check("rst_rx_we", bus.rx_we, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rx_ovf", rx_ovf, 0);
            check("rst_sck", bus.sck, 0);
            check("rst_mosi", bus.mosi, 0);
            check("rst_rx_din", bus.rx_din, 0);
            m_active = 0;
            last_cpol = 0;
         end else begin
            if (bus.tx_re) tre_cyc.push_back(cyc);
            if (bus.rx_we) begin
               we_cyc.push_back(cyc);
               we_data.push_back(bus.rx_din);
            end
            if (done) done_cyc.push_back(cyc);
            if (rx_ovf) ovf_cyc.push_back(cyc);

            exp_tre = 0; exp_busy = 0; exp_done = 0; exp_we = 0; exp_ovf = 0;
            exp_sck = last_cpol; exp_mosi = 0; j = 0;
            if (m_active) begin
               k = cyc - m_start;
               len = 2 * DW * (m_d + 1);
               exp_busy = 1;
               if (k <= len) begin
                  edges = (k - 1) / (m_d + 1);
                  exp_sck = m_cpol ^ ((edges % 2) == 1);
                  if (m_cpha) j = (edges <= 1) ? 0 : (edges - 1) / 2;
                  else j = edges / 2;
                  if (j > DW - 1) j = DW - 1;
               end else begin
                  exp_sck = m_cpol;
                  j = DW - 1;
                  exp_done = !clr;
                  exp_we = !clr && !rx_full;
                  exp_ovf = !clr && rx_full;
               end
               exp_mosi = m_tx[DW-1-j];
               check("mosi", bus.mosi, exp_mosi);
            end else begin
               exp_tre = en && !bus.tx_empty && !clr;
            end
            check("tx_re", bus.tx_re, exp_tre);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("rx_we", bus.rx_we, exp_we);
            check("rx_ovf", rx_ovf, exp_ovf);
            check("sck", bus.sck, exp_sck);
            if (exp_done) check("rx_din", bus.rx_din, m_rx);

            if (m_active) begin
               if (clr || k == len + 1) m_active = 0;
            end else if (exp_tre) begin
               m_active = 1;
               m_start = cyc;
               m_d = int'(div);
               m_cpol = cpol;
               m_cpha = cpha;
               m_tx = bus.tx_dout;
               m_rx = loopback ? bus.tx_dout : pat;
            end
            last_cpol = cpol;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      tx_mem[wr_ptr[3:0]] = w;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   function automatic int ev_count(input int sel);
      case (sel)
         0: return tre_cyc.size();
         1: return we_cyc.size();
         default: return done_cyc.size();
      endcase
   endfunction

   task automatic wait_ev(input int sel, input int target, input int max_cyc, input string name);
      int n;
      n = 0;
      while (ev_count(sel) < target && n < max_cyc) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, ev_count(sel) >= target, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int n0, w0, d0, o0, r0;
      logic [DW-1:0] words [3];
      words[0] = 8'h11; words[1] = 8'h96; words[2] = 8'hE7;
      rst = 0; clr = 0; en = 0; cpol = 0; cpha = 0; div = 4'd0;
      rx_full = 0; loopback = 1; pat = '0;
      for (int i = 0; i < 16; i++) tx_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_sck", bus.sck, 0);
      rst = 1;
      en = 1;
      idle(2);

      // div=0, mode 0, loopback 0xA5; en dropped mid-transfer.
      n0 = tre_cyc.size(); w0 = we_cyc.size(); r0 = sck_rises;
      push(8'hA5);
      wait_ev(0, n0 + 1, 20, "t1_start");
      en = 0;
      wait_ev(1, w0 + 1, 40, "t1_rx_we");
      idle(2);
      if (we_cyc.size() > w0 && tre_cyc.size() > n0) begin
         check("t1_latency", we_cyc[w0] - tre_cyc[n0], 17);
         check("t1_rx_din", we_data[w0], 8'hA5);
      end
      check("t1_sck_rises", sck_rises - r0, 8);
      en = 1;

      // div=3, mode 3, slave returns 0xC3; div changed while busy is ignored.
      cpol = 1; cpha = 1; div = 4'd3; loopback = 0; pat = 8'hC3;
      idle(2);
      n0 = tre_cyc.size(); w0 = we_cyc.size(); d0 = done_cyc.size();
      push(8'h3C);
      wait_ev(0, n0 + 1, 20, "t2_start");
      div = 4'd0;
      wait_ev(2, d0 + 1, 100, "t2_done");
      idle(2);
      if (done_cyc.size() > d0 && tre_cyc.size() > n0 && we_cyc.size() > w0) begin
         check("t2_xfer_len", done_cyc[d0] - tre_cyc[n0] - 1, 64);
         check("t2_rx_din", we_data[w0], 8'hC3);
      end
      check("t2_sck_idle", bus.sck, 1);
      check("t2_busy_idle", busy, 0);

      // RX FIFO full: word dropped, overflow flagged.
      cpol = 0; cpha = 1; div = 4'd1; loopback = 1;
      idle(2);
      rx_full = 1;
      w0 = we_cyc.size(); d0 = done_cyc.size(); o0 = ovf_cyc.size();
      push(8'h5A);
      wait_ev(2, d0 + 1, 60, "t3_done");
      idle(2);
      check("t3_ovf_count", ovf_cyc.size() - o0, 1);
      check("t3_we_count", we_cyc.size() - w0, 0);
      check("t3_done_count", done_cyc.size() - d0, 1);
      if (ovf_cyc.size() > o0 && done_cyc.size() > d0)
         check("t3_ovf_at_done", ovf_cyc[o0], done_cyc[d0]);
      rx_full = 0;

      // Three queued words back to back.
      cpol = 1; cpha = 0; div = 4'd0;
      idle(2);
      n0 = tre_cyc.size(); w0 = we_cyc.size();
      for (int i = 0; i < 3; i++) push(words[i]);
      wait_ev(1, w0 + 3, 100, "t4_rx_we");
      idle(1);
      if (we_cyc.size() >= w0 + 3 && tre_cyc.size() >= n0 + 3) begin
         for (int i = 0; i < 3; i++) begin
            check("t4_rx_din", we_data[w0+i], words[i]);
            check("t4_latency", we_cyc[w0+i] - tre_cyc[n0+i], 17);
         end
         for (int i = 1; i < 3; i++) check("t4_spacing", tre_cyc[n0+i] - tre_cyc[n0+i-1], 18);
      end

      // Abort after the fifth edge; next queued word still goes through.
      n0 = tre_cyc.size(); w0 = we_cyc.size(); d0 = done_cyc.size();
      push(8'hC0);
      push(8'h3F);
      wait_ev(0, n0 + 1, 20, "t5_start");
      idle(5);
      clr = 1;
      idle(1);
      clr = 0;
      check("t5_busy_after_clr", busy, 0);
      check("t5_sck_after_clr", bus.sck, 1);
      check("t5_no_rx_we", we_cyc.size() - w0, 0);
      wait_ev(1, w0 + 1, 60, "t5_rx_we");
      idle(1);
      if (we_cyc.size() > w0) check("t5_rx_din", we_data[w0], 8'h3F);
      check("t5_done_count", done_cyc.size() - d0, 1);
      check("t5_pops", tre_cyc.size() - n0, 2);

      // Asynchronous reset in the middle of a transfer.
      cpol = 0; cpha = 1; div = 4'd2;
      idle(2);
      n0 = tre_cyc.size(); w0 = we_cyc.size(); d0 = done_cyc.size();
      push(8'h77);
      wait_ev(0, n0 + 1, 20, "t6_start");
      idle(10);
      @(posedge clk);
      #2;
      check("t6_busy_before", busy, 1);
      rst = 0;
      #1;
      check("t6_tx_re", bus.tx_re, 0);
      check("t6_rx_we", bus.rx_we, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_rx_ovf", rx_ovf, 0);
      check("t6_sck", bus.sck, 0);
      check("t6_mosi", bus.mosi, 0);
      idle(3);
      rst = 1;
      idle(6);
      check("t6_no_pop", tre_cyc.size() - n0, 1);
      check("t6_no_rx_we", we_cyc.size() - w0, 0);
      check("t6_no_done", done_cyc.size() - d0, 0);
      check("t6_tx_re_idle", bus.tx_re, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
